imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit words in the shared instruction memory.
REQ-002 Parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 f_req  input  1  fetch-port request; held high with f_addr stable until f_gnt.
REQ-006 f_addr  input  ADDR_W  fetch byte address.
REQ-007 f_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 f_valid  output  1  one-cycle pulse: f_data/f_err valid.
REQ-009 f_data  output  32  fetched word.
REQ-010 f_err  output  1  fetch address misaligned or out of range; qualified by f_valid.
REQ-011 l_req, l_we  input  1 each  loader request; 1 = write, 0 = read; held with l_addr/l_wdata until l_gnt.
REQ-012 l_addr, l_wdata  input  ADDR_W, 32  loader byte address and write data.
REQ-013 l_gnt, l_valid, l_err  output  1 each  loader accept pulse, completion pulse (reads and writes), error flag.
REQ-014 l_rdata  output  32  loader read data; holds its previous value after writes.
REQ-015 m_en, m_we  output  1 each  memory access strobe and write enable.
REQ-016 m_addr  output  ADDR_W  memory word index (byte address >> 2).
REQ-017 m_wdata  output  32  memory write data.
REQ-018 m_rdata  input  32  memory read data, valid exactly one cycle after m_en.

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE; IDLE -> ISSUE when any req high; ISSUE -> CAPTURE unconditionally; CAPTURE -> IDLE unconditionally.
REQ-020 Arbitration happens only in IDLE; the winner's request is registered (owner, we, addr, wdata) on the IDLE -> ISSUE edge.
REQ-021 Single requester wins outright; with both high, the port not granted last wins (round-robin); the last-grant pointer resets to loader, so fetch wins the first tie.
REQ-022 In ISSUE: owner's gnt = 1, m_en = 1 (unless error), m_we = registered we, m_addr = registered addr >> 2, m_wdata = registered wdata.
REQ-023 In CAPTURE: m_rdata is latched into the owner's data register (reads only); on the following cycle the owner's valid = 1 for exactly one cycle.
REQ-024 Latency: req sampled in IDLE at cycle N -> gnt at N+1 -> valid at N+3; peak throughput one access per 3 cycles.
REQ-025 The valid pulse of one access coincides with the next IDLE cycle; a new arbitration in that cycle is permitted.
REQ-026 Error: registered addr[1:0] != 0, or (addr >> 2) >= MEM_WORDS -> m_en = 0 in ISSUE, gnt still pulses, valid pulses with err = 1, and the data register is unchanged.
REQ-027 err = 0 on every error-free completion.
REQ-028 A request dropped after arbitration still completes; a request dropped before arbitration is ignored.
REQ-029 Non-owner gnt/valid are 0 in every cycle.

Reset
REQ-030 While rst_n = 0 at posedge clk: state = IDLE, last-grant = loader, all gnt/valid/err/m_en/m_we = 0, m_addr/m_wdata/f_data/l_rdata = 0.
REQ-031 Reset mid-access abandons it: no valid pulse, and no memory write is issued after the reset edge.

Structure
REQ-032 A shared package holds the FSM state enum, the owner encoding (FETCH/LOAD), and the word-index shift constant 2.
REQ-033 No sub-module; the round-robin decision stays inline.

Verification
REQ-034 Fetch-only: f_req, f_addr = 0x8, mem[2] = 0xDEADBEEF -> f_gnt at N+1, m_addr = 2, f_valid at N+3, f_data = 0xDEADBEEF, f_err = 0.
REQ-035 Tie: f_req and l_req held high continuously -> grants F, L, F, L... on cycles N+1, N+4, N+7, N+10.
REQ-036 Loader write then fetch: l_we = 1, l_addr = 0x10, l_wdata = 0x12345678, then f_addr = 0x10 -> f_data = 0x12345678; l_rdata unchanged by the write.
REQ-037 Errors: f_addr = 0x6 -> f_err = 1, m_en never high; f_addr = 0x400 with MEM_WORDS = 256 -> f_err = 1.
REQ-038 Reset mid-access: rst_n low during the CAPTURE of a loader write -> no l_valid, all outputs 0, next fetch wins the first tie.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared FSM states, port-owner encoding and word-index shift
package imem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;
  typedef enum logic {FETCH = 1'b0, LOAD = 1'b1} owner_e;
  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter giving a fetch port and a loader port
// alternating access to one single-cycle-latency instruction memory
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [31:0]       f_data,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_valid,
  output logic              l_err,
  output logic [31:0]       l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);
  state_e state_q, state_d;
  owner_e last_q, last_d, own_q, own_d, win;
  logic we_q, we_d, vld_q, vld_d, err_q, err_d, bad, issue;
  logic [ADDR_W-1:0] addr_q, addr_d, widx;
  logic [31:0] wdata_q, wdata_d, f_data_q, f_data_d, l_rdata_q, l_rdata_d;
  assign widx = addr_q >> WORD_SHIFT;
  assign bad = (addr_q[1:0] != 2'b00) || (widx >= ADDR_W'(MEM_WORDS));
  // on a tie the port that did not win last time takes the slot
  assign win = (f_req && l_req) ? ((last_q == LOAD) ? FETCH : LOAD) : (f_req ? FETCH : LOAD);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    own_d = own_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    f_data_d = f_data_q;
    l_rdata_d = l_rdata_q;
    vld_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: if (f_req || l_req) begin
        state_d = ISSUE;
        last_d = win;
        own_d = win;
        we_d = (win == LOAD) && l_we;
        addr_d = (win == LOAD) ? l_addr : f_addr;
        wdata_d = (win == LOAD) ? l_wdata : '0;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d = IDLE;
        vld_d = 1'b1;
        err_d = bad;
        f_data_d = (!bad && !we_q && own_q == FETCH) ? m_rdata : f_data_q;
        l_rdata_d = (!bad && !we_q && own_q == LOAD) ? m_rdata : l_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= LOAD;
      own_q <= FETCH;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      f_data_q <= '0;
      l_rdata_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      own_q <= own_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      f_data_q <= f_data_d;
      l_rdata_q <= l_rdata_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end
  // own_q still names the finished access during its valid cycle
  assign issue = state_q == ISSUE;
  assign f_gnt = issue && own_q == FETCH;
  assign l_gnt = issue && own_q == LOAD;
  assign f_valid = vld_q && own_q == FETCH;
  assign l_valid = vld_q && own_q == LOAD;
  assign f_err = f_valid && err_q;
  assign l_err = l_valid && err_q;
  assign f_data = f_data_q;
  assign l_rdata = l_rdata_q;
  assign m_en = issue && !bad;
  assign m_we = issue && we_q;
  assign m_addr = issue ? widx : '0;
  assign m_wdata = issue ? wdata_q : '0;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: random and directed traffic on both ports checked against
// a transaction-level schedule model
module tb_imem_arbiter;
  localparam int MW = 256;
  logic clk = 1'b0, rst_n = 1'b0;
  logic f_req = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0, m_rdata = '0;
  logic f_gnt, f_valid, f_err, l_gnt, l_valid, l_err, m_en, m_we;
  logic [31:0] f_data, l_rdata, m_addr, m_wdata;
  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];
  int n_chk = 0, n_fail = 0, c = 0, free_c = 0, gc = -1, vc = -1;
  bit act = 0, r_own = 0, r_we = 0, r_err = 0, last_l = 1;
  logic [31:0] r_addr = '0, r_wdata = '0, r_data = '0, mf = '0, ml = '0, saved;
  bit fp = 0, lp = 0, lwe = 0, hold = 0, rnd = 0, rst_drv = 0;
  logic [31:0] fa = '0, la = '0, lwd = '0;

  always #5 clk = ~clk;

  imem_arbiter #(.MEM_WORDS(MW), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_valid(l_valid), .l_err(l_err), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always @(posedge clk)
    if (m_en) begin
      if (m_we) mem[m_addr[7:0]] <= m_wdata;
      else m_rdata <= mem[m_addr[7:0]];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, c, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= MW);
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a = 32'($urandom_range(0, 299)) << 2;
    if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  // one cycle: check outputs, drive inputs, then advance the schedule model
  task automatic step();
    bit iss = act && c == gc;
    bit val = act && c == vc;
    bit wl;
    if (val && !r_err && !r_we) begin
      if (r_own) ml = r_data;
      else mf = r_data;
    end
    chk("f_gnt", 32'(f_gnt), 32'(iss && !r_own));
    chk("l_gnt", 32'(l_gnt), 32'(iss && r_own));
    chk("f_valid", 32'(f_valid), 32'(val && !r_own));
    chk("l_valid", 32'(l_valid), 32'(val && r_own));
    chk("f_err", 32'(f_err), 32'(val && !r_own && r_err));
    chk("l_err", 32'(l_err), 32'(val && r_own && r_err));
    chk("m_en", 32'(m_en), 32'(iss && !r_err));
    chk("m_we", 32'(m_we), 32'(iss && r_we));
    if (iss) begin
      chk("m_addr", m_addr, r_addr >> 2);
      if (r_we) chk("m_wdata", m_wdata, r_wdata);
    end
    chk("f_data", f_data, mf);
    chk("l_rdata", l_rdata, ml);
    if (rnd) begin
      if (!fp && $urandom_range(0, 2) == 0) begin fp = 1; fa = rnd_addr(); end
      else if (fp && $urandom_range(0, 15) == 0) fp = 0;
      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1; la = rnd_addr(); lwe = 1'($urandom_range(0, 1)); lwd = $urandom;
      end else if (lp && $urandom_range(0, 15) == 0) lp = 0;
    end
    rst_n = rst_drv; f_req = fp; f_addr = fa; l_req = lp; l_we = lwe; l_addr = la; l_wdata = lwd;
    if (!rst_drv) begin
      act = 0; last_l = 1; mf = '0; ml = '0; free_c = c + 1; fp = 0; lp = 0;
    end else if (c >= free_c && (fp || lp)) begin
      wl = (fp && lp) ? !last_l : lp;
      act = 1; r_own = wl; r_we = wl && lwe; r_addr = wl ? la : fa; r_wdata = lwd;
      r_err = is_err(r_addr);
      r_data = r_err ? '0 : ref_mem[r_addr[9:2]];
      if (r_we && !r_err) ref_mem[r_addr[9:2]] = lwd;
      gc = c + 1; vc = c + 3; free_c = c + 3; last_l = wl;
      if (!hold) begin
        if (wl) lp = 0;
        else fp = 0;
      end
    end
    @(negedge clk);
    c++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[2] = 32'hDEADBEEF; ref_mem[2] = 32'hDEADBEEF;
    @(negedge clk);
    steps(3);
    rst_drv = 1;
    steps(2);
    fp = 1; fa = 32'h8;
    steps(6);
    chk("fetch_deadbeef", f_data, 32'hDEADBEEF);
    saved = ml;
    lp = 1; lwe = 1; la = 32'h10; lwd = 32'h12345678;
    steps(4);
    fp = 1; fa = 32'h10;
    steps(5);
    chk("write_then_fetch", f_data, 32'h12345678);
    chk("l_rdata_after_write", l_rdata, saved);
    fp = 1; fa = 32'h6;
    steps(4);
    fp = 1; fa = 32'h400;
    steps(4);
    fp = 1; lp = 1; lwe = 0; fa = 32'h4; la = 32'h8; hold = 1;
    steps(13);
    hold = 0; fp = 0; lp = 0;
    steps(4);
    rnd = 1;
    steps(2000);
    rnd = 0; fp = 0; lp = 0;
    steps(4);
    lp = 1; lwe = 1; la = 32'h20; lwd = 32'hCAFEF00D;
    steps(2);
    rst_drv = 0;
    step();
    chk("rst_strobes", 32'({f_gnt, f_valid, f_err, l_gnt, l_valid, l_err, m_en, m_we}), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_f_data", f_data, 32'h0);
    chk("rst_l_rdata", l_rdata, 32'h0);
    rst_drv = 1; fp = 1; lp = 1; lwe = 0; fa = 32'h4; la = 32'h8; hold = 1;
    step();
    chk("tie_after_rst", 32'(f_gnt), 32'h1);
    steps(8);
    hold = 0; fp = 0; lp = 0;
    steps(5);
    chk("post_rst_mem", mem[8], 32'hCAFEF00D);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
